burst_ram_responder: RTL and testbench

//  Responder end of the br_* burst RAM interface driven by the instruction/data cache arbiter.

---
 rtl/burst_ram_responder_if.sv | 27 ++
 rtl/burst_ram_responder.sv | 189 ++++++++++++++++++
 tb/tb_burst_ram_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ram_responder_if.sv
// br_* burst RAM command/data bundle between the cache arbiter (master)
// and the burst RAM responder (slave).
interface burst_ram_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              br_cmd;
  logic              br_cmd_en;
  logic [ADDR_W-1:0] br_addr;
  logic [DATA_W-1:0] br_wr_data;
  logic [MASK_W-1:0] br_data_mask;
  logic [DATA_W-1:0] br_rd_data;
  logic              br_rd_data_valid;
  logic              br_busy;

  modport master (
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy
  );

  modport slave (
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy
  );
endinterface

// File: rtl/burst_ram_responder.sv
// Burst RAM responder: serves one read or write burst at a time against an
// internal word-addressed array that is deliberately left out of reset.
module burst_ram_responder #(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int READ_LATENCY            = 2,
  parameter int INIT_CYCLES             = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_ram_responder_if.slave  br
);
  localparam int N      = RAM_DEPTH_BITWIDTH;
  localparam int W      = RAM_BURST_DATA_BITWIDTH;
  localparam int DEPTH  = 1 << N;
  localparam int MASK_W = W / 8;

  localparam int CNT_MAX_A = (INIT_CYCLES > READ_LATENCY) ? INIT_CYCLES : READ_LATENCY;
  localparam int CNT_MAX   = (CNT_MAX_A > RAM_BURST_DATA_COUNT) ? CNT_MAX_A : RAM_BURST_DATA_COUNT;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(RAM_BURST_DATA_COUNT - 1);
  localparam logic [N-1:0]     ADDR_ONE  = N'(1);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_WR_BURST = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       ptr_q, ptr_d;
  logic [W-1:0]       rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               busy_q, busy_d;

  logic               we_s;
  logic [N-1:0]       waddr_s;
  logic [W-1:0]       wdata_s;
  logic [MASK_W-1:0]  wmask_s;

  logic [W-1:0]       mem_q [DEPTH];

  // State, counter, pointer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= CNT_ZERO;
      ptr_q      <= {N{1'b0}};
      rd_data_q  <= {W{1'b0}};
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next state; cnt counts init cycles, read latency or burst beats
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (br.br_cmd_en) begin
          if (!br.br_cmd) begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_ZERO;
          end else if (RAM_BURST_DATA_COUNT > 1) begin
            state_d = ST_WR_BURST;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_RD_BURST;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_RD_BURST, ST_WR_BURST: begin
        if (cnt_q == BEAT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs and array port: ptr_q always holds the next word to read or write
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    ptr_d      = ptr_q;
    we_s       = 1'b0;
    waddr_s    = ptr_q;
    wdata_s    = br.br_wr_data;
    wmask_s    = br.br_data_mask;
    case (state_q)
      ST_IDLE: begin
        if (br.br_cmd_en) begin
          if (br.br_cmd) begin
            we_s    = 1'b1;
            waddr_s = br.br_addr;
            ptr_d   = br.br_addr + ADDR_ONE;
          end else begin
            ptr_d   = br.br_addr;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[ptr_q];
          ptr_d      = ptr_q + ADDR_ONE;
        end else begin
          rd_valid_d = 1'b0;
        end
      end
      ST_RD_BURST: begin
        if (cnt_q != BEAT_LAST) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[ptr_q];
          ptr_d      = ptr_q + ADDR_ONE;
        end else begin
          rd_valid_d = 1'b0;
        end
      end
      ST_WR_BURST: begin
        we_s  = 1'b1;
        ptr_d = ptr_q + ADDR_ONE;
      end
      default: begin
        rd_valid_d = 1'b0;
      end
    endcase
  end

  // Byte-masked array write; a set mask bit protects that byte
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wmask_s[b]) begin
          mem_q[waddr_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
        end
      end
    end
  end

  assign br.br_rd_data       = rd_data_q;
  assign br.br_rd_data_valid = rd_valid_q;
  assign br.br_busy          = busy_q;
endmodule

// File: tb/tb_burst_ram_responder.sv
// Randomized bench for burst_ram_responder against a transaction-level model
// that predicts busy, valid and read data per absolute cycle number.
module tb_burst_ram_responder;
  localparam int N = 4;
  localparam int W = 64;
  localparam int C = 4;
  localparam int L = 2;
  localparam int I = 4;
  localparam int NEVER = 32'h3fff_ffff;

  typedef struct {
    int           c;
    logic [W-1:0] d;
    bit           k;
  } rd_exp_t;

  logic clk;
  logic rst;

  burst_ram_responder_if #(.ADDR_W(N), .DATA_W(W)) br_bus ();

  burst_ram_responder #(
    .RAM_DEPTH_BITWIDTH      (N),
    .RAM_BURST_DATA_BITWIDTH (W),
    .RAM_BURST_DATA_COUNT    (C),
    .READ_LATENCY            (L),
    .INIT_CYCLES             (I)
  ) dut (
    .clk (clk),
    .rst (rst),
    .br  (br_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;
  int busy_until;
  int wr_left;
  int first_valid;
  logic [N-1:0] wr_ptr;
  logic [W-1:0] mm [1<<N];
  bit           mk [1<<N];
  rd_exp_t      rdq [$];
  logic [W-1:0] seen [$];
  logic [W-1:0] wd [C];
  logic [7:0]   wm [C];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_write(input logic [N-1:0] a, input logic [W-1:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++) begin
      if (!m[b]) mm[a][b*8 +: 8] = d[b*8 +: 8];
    end
    if (m == 8'h00) mk[a] = 1'b1;
  endtask

  // Apply the edge ending the current cycle to the model, then check the next cycle.
  task automatic clk_cycle();
    logic [N-1:0] a;
    rd_exp_t e;
    if (wr_left > 0) begin
      model_write(wr_ptr, br_bus.br_wr_data, br_bus.br_data_mask);
      wr_ptr  = wr_ptr + 4'd1;
      wr_left = wr_left - 1;
    end else if (br_bus.br_cmd_en && cyc > busy_until) begin
      if (br_bus.br_cmd) begin
        model_write(br_bus.br_addr, br_bus.br_wr_data, br_bus.br_data_mask);
        wr_ptr     = br_bus.br_addr + 4'd1;
        wr_left    = C - 1;
        busy_until = cyc + C - 1;
      end else begin
        for (int k = 0; k < C; k++) begin
          a = br_bus.br_addr + 4'(k);
          e.c = cyc + L + 1 + k;
          e.d = mm[a];
          e.k = mk[a];
          rdq.push_back(e);
        end
        busy_until = cyc + L + C;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("busy", {63'd0, br_bus.br_busy}, {63'd0, (cyc <= busy_until)});
    if (rdq.size() > 0 && rdq[0].c == cyc) begin
      e = rdq.pop_front();
      check("valid", {63'd0, br_bus.br_rd_data_valid}, 64'd1);
      if (e.k) check("rd_data", br_bus.br_rd_data, e.d);
      seen.push_back(br_bus.br_rd_data);
    end else begin
      check("valid", {63'd0, br_bus.br_rd_data_valid}, 64'd0);
    end
    if (br_bus.br_rd_data_valid && first_valid < 0) first_valid = cyc;
  endtask

  task automatic quiet();
    br_bus.br_cmd_en    = 1'b0;
    br_bus.br_wr_data   = {$urandom, $urandom};
    br_bus.br_data_mask = 8'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    quiet();
    while ((cyc <= busy_until || rdq.size() > 0) && g < 50) begin
      clk_cycle();
      g++;
    end
    if (g >= 50) check("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_read(input logic [N-1:0] a);
    wait_idle();
    seen.delete();
    br_bus.br_cmd_en = 1'b1;
    br_bus.br_cmd    = 1'b0;
    br_bus.br_addr   = a;
    clk_cycle();
    quiet();
  endtask

  task automatic issue_write(input logic [N-1:0] a);
    wait_idle();
    br_bus.br_cmd_en    = 1'b1;
    br_bus.br_cmd       = 1'b1;
    br_bus.br_addr      = a;
    br_bus.br_wr_data   = wd[0];
    br_bus.br_data_mask = wm[0];
    clk_cycle();
    br_bus.br_cmd_en = 1'b0;
    for (int k = 1; k < C; k++) begin
      br_bus.br_wr_data   = wd[k];
      br_bus.br_data_mask = wm[k];
      clk_cycle();
    end
    quiet();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_busy_now", {63'd0, br_bus.br_busy}, 64'd1);
    check("rst_valid_now", {63'd0, br_bus.br_rd_data_valid}, 64'd0);
    rdq.delete();
    wr_left    = 0;
    busy_until = NEVER;
    clk_cycle();
    clk_cycle();
    rst        = 1'b0;
    busy_until = cyc + I - 1;
  endtask

  initial begin
    logic [W-1:0] keep9;
    int rel;
    int g;
    total = 0; bad = 0; cyc = 0; wr_left = 0; wr_ptr = '0;
    busy_until = NEVER; first_valid = -1;
    for (int i = 0; i < (1<<N); i++) begin
      mm[i] = '0;
      mk[i] = 1'b0;
    end
    rst = 1'b1;
    br_bus.br_cmd = 1'b0; br_bus.br_cmd_en = 1'b1; br_bus.br_addr = 4'd0;
    br_bus.br_wr_data = 64'd0; br_bus.br_data_mask = 8'h00;

    // 1: init window with cmd_en held high; first read accepted in cycle 5
    clk_cycle();
    clk_cycle();
    check("reset_rd_data", br_bus.br_rd_data, 64'd0);
    rst = 1'b0;
    rel = cyc;
    busy_until = cyc + I - 1;
    first_valid = -1;
    repeat (12) clk_cycle();
    check("first_valid_cycle", 64'(first_valid), 64'(rel + 4 + L + 1));
    quiet();

    // fill the whole array with known data
    for (int base = 0; base < (1<<N); base += C) begin
      for (int k = 0; k < C; k++) begin
        wd[k] = {$urandom, $urandom};
        wm[k] = 8'h00;
      end
      issue_write(4'(base));
    end

    // 2: write then immediate read
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wd[2] = 64'hCCCC_CCCC_CCCC_CCCC; wd[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    for (int k = 0; k < C; k++) wm[k] = 8'h00;
    issue_write(4'd2);
    issue_read(4'd2);
    wait_idle();
    check("wr_rd_w0", seen[0], 64'hAAAA_AAAA_AAAA_AAAA);
    check("wr_rd_w3", seen[3], 64'hDDDD_DDDD_DDDD_DDDD);

    // 3: byte mask
    wd[0] = 64'h1111_2222_3333_4444;
    issue_write(4'd5);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; wm[0] = 8'h0F;
    for (int k = 1; k < C; k++) wm[k] = 8'hFF;
    issue_write(4'd5);
    issue_read(4'd5);
    wait_idle();
    check("mask_word", seen[0], 64'hFFFF_FFFF_3333_4444);

    // 4: address wrap
    for (int k = 0; k < C; k++) begin
      wd[k] = 64'(k + 1);
      wm[k] = 8'h00;
    end
    issue_write(4'd14);
    issue_read(4'd0);
    wait_idle();
    check("wrap_rd0_w0", seen[0], 64'd3);
    check("wrap_rd0_w1", seen[1], 64'd4);
    issue_read(4'd14);
    wait_idle();
    check("wrap_rd14_w0", seen[0], 64'd1);
    check("wrap_rd14_w3", seen[3], 64'd4);

    // 5: command pulse during a read burst is dropped
    keep9 = mm[9];
    issue_read(4'd9);
    clk_cycle();
    clk_cycle();
    br_bus.br_cmd_en = 1'b1; br_bus.br_cmd = 1'b1; br_bus.br_addr = 4'd9;
    br_bus.br_wr_data = ~keep9; br_bus.br_data_mask = 8'h00;
    clk_cycle();
    quiet();
    check("busy_pulse_burst_w0", seen[0], keep9);
    issue_read(4'd9);
    wait_idle();
    check("busy_pulse_mem9", seen[0], keep9);

    // 6: reset during the second valid word
    issue_read(4'd4);
    g = 0;
    while (seen.size() < 2 && g < 20) begin
      clk_cycle();
      g++;
    end
    check("reset_mid_reached", 64'(seen.size()), 64'd2);
    apply_reset();
    issue_read(4'd2);
    wait_idle();
    check("after_reset_w0", seen[0], 64'hAAAA_AAAA_AAAA_AAAA);

    // random traffic, including commands while busy and masked writes
    for (int n = 0; n < 600; n++) begin
      br_bus.br_cmd_en    = ($urandom_range(0, 2) == 0);
      br_bus.br_cmd       = 1'($urandom);
      br_bus.br_addr      = 4'($urandom);
      br_bus.br_wr_data   = {$urandom, $urandom};
      br_bus.br_data_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      clk_cycle();
    end
    wait_idle();
    for (int a = 0; a < (1<<N); a += C) begin
      issue_read(4'(a));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
